// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns PCF, next-PC selection and the
// variable-latency instruction-memory handshake, presenting fetched words to decode.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StDrop  = 2'd1,
    StHold  = 2'd2
  } fetchStateT;

  fetchStateT      state, stateNext;
  logic [XLEN-1:0] pcF, pcFNext;
  logic [XLEN-1:0] dropAddr, dropAddrNext;
  logic [31:0]     holdInstr, holdInstrNext;
  logic [XLEN-1:0] holdPc, holdPcNext;
  logic [31:0]     instrDNext;
  logic [XLEN-1:0] pcDNext, pcPlus4DNext;
  logic            validDNext;
  logic            imemReqNext;
  logic [XLEN-1:0] imemAddrNext;

  logic            redirect;
  logic            accept;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pcPlus4;

  assign redirect = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
  assign accept   = !StallF && !StallD;
  assign target   = (PCSrcE == 2'b10) ? {ALUResultE[XLEN-1:1], 1'b0} : PCTargetE;
  assign pcPlus4  = pcF + XLEN'(4);

  // Next-state, next-PC and IF/ID load selection
  always_comb begin
    stateNext     = state;
    pcFNext       = pcF;
    dropAddrNext  = dropAddr;
    holdInstrNext = holdInstr;
    holdPcNext    = holdPc;
    instrDNext    = NOP;
    pcDNext       = '0;
    pcPlus4DNext  = '0;
    validDNext    = 1'b0;

    unique case (state)
      StFetch: begin
        if (redirect) begin
          pcFNext = target;
          if (!imem_ready) begin
            dropAddrNext = pcF;
            stateNext    = StDrop;
          end
        end else if (imem_ready) begin
          if (accept) begin
            instrDNext   = imem_rdata;
            pcDNext      = pcF;
            pcPlus4DNext = pcPlus4;
            validDNext   = 1'b1;
            pcFNext      = pcPlus4;
          end else begin
            holdInstrNext = imem_rdata;
            holdPcNext    = pcF;
            stateNext     = StHold;
          end
        end
      end
      StDrop: begin
        if (redirect) pcFNext = target;
        if (imem_ready) stateNext = StFetch;
      end
      StHold: begin
        if (redirect) begin
          pcFNext   = target;
          stateNext = StFetch;
        end else if (accept) begin
          instrDNext   = holdInstr;
          pcDNext      = holdPc;
          pcPlus4DNext = holdPc + XLEN'(4);
          validDNext   = 1'b1;
          pcFNext      = pcPlus4;
          stateNext    = StFetch;
        end
      end
      default: stateNext = StFetch;
    endcase

    // Flush and redirect beat stall, which beats the per-state load
    if (FlushD || redirect) begin
      instrDNext   = NOP;
      pcDNext      = '0;
      pcPlus4DNext = '0;
      validDNext   = 1'b0;
    end else if (StallD) begin
      instrDNext   = InstrD;
      pcDNext      = PCD;
      pcPlus4DNext = PCPlus4D;
      validDNext   = ValidD;
    end
  end

  // Request outputs are registered from the upcoming state
  always_comb begin
    imemReqNext  = (stateNext != StHold);
    imemAddrNext = (stateNext == StDrop) ? dropAddrNext : pcFNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StFetch;
      pcF       <= RESET_PC;
      dropAddr  <= '0;
      holdInstr <= NOP;
      holdPc    <= '0;
      InstrD    <= NOP;
      PCD       <= '0;
      PCPlus4D  <= '0;
      ValidD    <= 1'b0;
      imem_req  <= 1'b1;
      imem_addr <= RESET_PC;
    end else begin
      state     <= stateNext;
      pcF       <= pcFNext;
      dropAddr  <= dropAddrNext;
      holdInstr <= holdInstrNext;
      holdPc    <= holdPcNext;
      InstrD    <= instrDNext;
      PCD       <= pcDNext;
      PCPlus4D  <= pcPlus4DNext;
      ValidD    <= validDNext;
      imem_req  <= imemReqNext;
      imem_addr <= imemAddrNext;
    end
  end

endmodule
